pulse_sync_mc: RTL and testbench
================================

PULSE_SYNC_MC -- requirements
Module: pulse_sync_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent toggle channels (1..32).
REQ-002 SHALL have parameter DEPTH, default 2, meaning synchronizer flop stages per channel (2..4).
REQ-003 SHALL have parameter CNT_W, default 4, meaning width of each per-channel pending-event counter (1..8).
REQ-004 SHALL have parameter RST_VAL, default 1'b0, meaning reset value of every synchronizer and edge flop.
REQ-005 SHALL have parameter TOGGLE_EARLY, default 0, meaning that when 1, edge detect taps stage DEPTH-2 instead of DEPTH-1 (legal only with DEPTH>=3).
REQ-006 SHALL have port dst_clk  input  1  sole clock; all flops on rising edge.
REQ-007 SHALL have port dst_rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port src_toggle  input  NUM_CH  asynchronous toggle per channel; each transition is one event.
REQ-009 SHALL have port dst_toggle  output  NUM_CH  synchronized toggle level (stage DEPTH-1).
REQ-010 SHALL have port dst_pulse  output  NUM_CH  one-cycle pulse per detected transition.
REQ-011 SHALL have port m_valid  output  1  a queued event is presented.
REQ-012 SHALL have port m_ready  input  1  consumer accepts the event when m_valid&&m_ready.
REQ-013 SHALL have port m_ch  output  CH_W=max(1,clog2(NUM_CH))  channel index of the presented event.
REQ-014 SHALL have port pend_any  output  1  OR of all counters non-zero, including the presented event.
REQ-015 SHALL have port ovf  output  NUM_CH  sticky per-channel overflow flag.
REQ-016 SHALL have port ovf_clr  input  NUM_CH  write-1-to-clear for ovf.

Function
REQ-017 SHALL synchronize each src_toggle bit through DEPTH flops; dst_toggle changes DEPTH edges after the first edge sampling the new level.
REQ-018 SHALL register the tapped stage into an edge flop; dst_pulse[i] = tap XOR edge flop, high exactly one cycle per transition.
REQ-019 SHALL increment counter[i] on dst_pulse[i] and decrement it when channel i is loaded into the output register; both in one cycle leaves it unchanged.
REQ-020 SHALL saturate counter[i] at 2^CNT_W-1; an increment at saturation (without simultaneous decrement) is dropped.
REQ-021 SHALL load the output register (m_valid, m_ch) when it is empty or being accepted, from the round-robin winner among channels with non-zero counter.
REQ-022 SHALL choose the winner as the lowest index at or above pointer ptr, wrapping to 0; after a load ptr = winner+1 modulo NUM_CH.
REQ-023 SHALL hold m_valid and m_ch stable while m_valid && !m_ready.
REQ-024 SHALL give m_valid high at the earliest 2 edges after dst_pulse, i.e. DEPTH+2 edges after sampling (DEPTH+1 with TOGGLE_EARLY); back-to-back acceptance sustains one event per cycle.
REQ-025 SHALL count an event in the counter until it is loaded; the loaded event is tracked by m_valid, so pend_any = m_valid OR any counter non-zero.

Reset
REQ-026 SHALL, with dst_rst high at an edge, set all sync and edge flops to RST_VAL, counters 0, ptr 0, m_valid 0, m_ch 0, ovf 0.
REQ-027 SHALL discard all pending and presented events on reset mid-operation; dst_pulse SHALL stay 0 in the first cycle after reset release.

Configuration
REQ-028 SHALL compile in overflow tracking when macro PULSE_SYNC_MC_OVF_EN is defined: ovf[i] set on a dropped increment, cleared by ovf_clr[i]; set wins on same cycle.
REQ-029 SHALL, without PULSE_SYNC_MC_OVF_EN, tie ovf to 0, ignore ovf_clr, and instantiate no overflow flops.

Structure
REQ-030 SHALL place the CH_W width function and parameter legality checks in shared package pulse_sync_pkg.
REQ-031 SHALL implement per-channel sync, edge detect and counter in sub-module pulse_sync_mc_ch, instantiated NUM_CH times; arbiter and output register live in the top.

Verification
REQ-032 SHALL cover: DEPTH=2, ch1 toggles once, m_ready=1 -> dst_pulse[1] one cycle, m_valid one cycle with m_ch=1, 4 edges after sampling.
REQ-033 SHALL cover: ch0,ch2,ch3 toggle same cycle, m_ready=1 -> m_ch sequence 0,2,3 on consecutive cycles, then pend_any=0.
REQ-034 SHALL cover: CNT_W=2, m_ready=0, ch0 toggled 5 times spaced 4 cycles -> counter 3, ovf[0]=1 (macro on), 4 events delivered after m_ready=1.
REQ-035 SHALL cover: m_valid held with m_ready=0 for 10 cycles -> m_ch unchanged; ovf_clr[0]=1 -> ovf[0]=0 next cycle.
REQ-036 SHALL cover: dst_rst asserted with 3 events pending -> m_valid=0, pend_any=0 next cycle, no events after release.
REQ-037 SHALL cover: RST_VAL=1 with src_toggle=all-ones through reset -> no dst_pulse after release.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared helpers for the multi-channel toggle synchronizer: the channel-index
// width function and the parameter legality check used at elaboration.
package pulse_sync_pkg;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int unsigned ch_w(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 1) begin
         w = int'($clog2(n));
      end
      return w;
   endfunction

   // True when the parameter set is within the supported ranges.
   function automatic bit params_ok(input int unsigned num_ch,
                                    input int unsigned depth,
                                    input int unsigned cnt_w,
                                    input int unsigned toggle_early);
      bit ok;
      ok = 1'b1;
      if (num_ch < 1 || num_ch > 32) ok = 1'b0;
      if (depth < 2 || depth > 4) ok = 1'b0;
      if (cnt_w < 1 || cnt_w > 8) ok = 1'b0;
      if (toggle_early > 1) ok = 1'b0;
      // Tapping one stage early still needs two stages ahead of the tap.
      if (toggle_early == 1 && depth < 3) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/pulse_sync_mc_ch.sv
// One channel of pulse_sync_mc: DEPTH-stage synchronizer, edge detector and a
// saturating pending-event counter. o_drop flags an increment lost to
// saturation so the top can keep an overflow record.
module pulse_sync_mc_ch
   import pulse_sync_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned CNT_W        = 4,
   parameter logic        RST_VAL      = 1'b0,
   parameter int unsigned TOGGLE_EARLY = 0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_toggle,
   input  logic i_dec,
   output logic o_toggle,
   output logic o_pulse,
   output logic o_nz,
   output logic o_drop
);

   localparam int unsigned TAP = (TOGGLE_EARLY != 0 && DEPTH >= 3) ? DEPTH - 2 : DEPTH - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [DEPTH-1:0] r_sync;
   logic             r_edge;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tap;
   logic             w_pulse;
   logic             w_drop;

   // Synchronizer chain and edge flop; bit 0 is the first stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {DEPTH{RST_VAL}};
         r_edge <= RST_VAL;
      end else begin
         r_sync <= {r_sync[DEPTH-2:0], i_toggle};
         r_edge <= w_tap;
      end
   end

   assign w_tap   = r_sync[TAP];
   assign w_pulse = w_tap ^ r_edge;

   // Counter next state: simultaneous increment and decrement cancel out.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_drop    = 1'b0;
      if (w_pulse && !i_dec) begin
         if (r_cnt == CNT_MAX) begin
            w_drop = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end else if (!w_pulse && i_dec) begin
         w_cnt_nxt = r_cnt - CNT_W'(1);
      end
   end

   // Pending-event counter register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign o_toggle = r_sync[DEPTH-1];
   assign o_pulse  = w_pulse;
   assign o_nz     = |r_cnt;
   assign o_drop   = w_drop;

endmodule

// File: rtl/pulse_sync_mc.sv
// Multi-channel toggle-to-pulse synchronizer with a round-robin event queue.
// Each channel counts detected transitions; the top arbitrates among channels
// with pending events and presents one event at a time on m_valid/m_ch.
// Optional build macro: PULSE_SYNC_MC_OVF_EN adds sticky per-channel overflow
// flags (ovf, cleared by ovf_clr); without it ovf is tied low.
module pulse_sync_mc
   import pulse_sync_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned CNT_W        = 4,
   parameter logic        RST_VAL      = 1'b0,
   parameter int unsigned TOGGLE_EARLY = 0,
   localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
   input  logic              dst_clk,
   input  logic              dst_rst,
   input  logic [NUM_CH-1:0] src_toggle,
   output logic [NUM_CH-1:0] dst_toggle,
   output logic [NUM_CH-1:0] dst_pulse,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CH_W-1:0]   m_ch,
   output logic              pend_any,
   output logic [NUM_CH-1:0] ovf,
   input  logic [NUM_CH-1:0] ovf_clr
);

   if (!params_ok(NUM_CH, DEPTH, CNT_W, TOGGLE_EARLY)) begin : g_param_err
      $error("pulse_sync_mc: illegal parameter combination");
   end

   logic [NUM_CH-1:0] w_req;
   logic [NUM_CH-1:0] w_dec;
   logic [NUM_CH-1:0] w_drop;
   logic              w_load;
   logic              w_found;
   logic              w_found_hi;
   logic              w_found_lo;
   logic [CH_W-1:0]   w_win;
   logic [CH_W-1:0]   w_win_hi;
   logic [CH_W-1:0]   w_win_lo;
   logic [CH_W-1:0]   w_ptr_nxt;

   logic              r_valid;
   logic [CH_W-1:0]   r_ch;
   logic [CH_W-1:0]   r_ptr;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pulse_sync_mc_ch #(
         .DEPTH        (DEPTH),
         .CNT_W        (CNT_W),
         .RST_VAL      (RST_VAL),
         .TOGGLE_EARLY (TOGGLE_EARLY)
      ) u_ch (
         .i_clk    (dst_clk),
         .i_rst    (dst_rst),
         .i_toggle (src_toggle[g]),
         .i_dec    (w_dec[g]),
         .o_toggle (dst_toggle[g]),
         .o_pulse  (dst_pulse[g]),
         .o_nz     (w_req[g]),
         .o_drop   (w_drop[g])
      );

      assign w_dec[g] = w_load & w_found & (w_win == CH_W'(g));
   end

   // The output register takes a new event when empty or being accepted.
   assign w_load = !r_valid || m_ready;

   // Round-robin pick: lowest requester at or above r_ptr, else lowest overall.
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_win_hi   = '0;
      w_win_lo   = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (w_req[i] && (CH_W'(i) >= r_ptr)) begin
            w_found_hi = 1'b1;
            w_win_hi   = CH_W'(i);
         end
         if (w_req[i]) begin
            w_found_lo = 1'b1;
            w_win_lo   = CH_W'(i);
         end
      end
      w_found   = w_found_hi | w_found_lo;
      w_win     = w_found_hi ? w_win_hi : w_win_lo;
      w_ptr_nxt = (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + CH_W'(1);
   end

   // Output register and arbitration pointer.
   always_ff @(posedge dst_clk) begin
      if (dst_rst) begin
         r_valid <= 1'b0;
         r_ch    <= '0;
         r_ptr   <= '0;
      end else if (w_load) begin
         r_valid <= w_found;
         if (w_found) begin
            r_ch  <= w_win;
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   assign m_valid  = r_valid;
   assign m_ch     = r_ch;
   // The presented event has already left its counter, so include m_valid.
   assign pend_any = r_valid | (|w_req);

`ifdef PULSE_SYNC_MC_OVF_EN
   logic [NUM_CH-1:0] r_ovf;

   // Sticky overflow: a new drop wins over a same-cycle clear.
   always_ff @(posedge dst_clk) begin
      if (dst_rst) begin
         r_ovf <= '0;
      end else begin
         r_ovf <= (r_ovf & ~ovf_clr) | w_drop;
      end
   end

   assign ovf = r_ovf;
`else
   logic w_unused;
   assign w_unused = ^{ovf_clr, w_drop};
   assign ovf      = '0;
`endif

endmodule

// File: tb/tb_pulse_sync_mc.sv
// Bench for pulse_sync_mc: directed scenarios followed by a randomized run,
// all compared every cycle against a behavioural model of the event queue.
// A second instance with RST_VAL=1 holds all-ones inputs through reset.
module tb_pulse_sync_mc;

   localparam int NCH  = 4;
   localparam int DEP  = 2;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] src;
   logic [NCH-1:0] clr;
   logic           ready;
   logic [NCH-1:0] d_toggle, d_pulse, d_ovf;
   logic           d_valid, d_pend;
   logic [1:0]     d_ch;

   logic [NCH-1:0] src1;
   logic [NCH-1:0] clr1;
   logic           ready1;
   logic [NCH-1:0] d1_toggle, d1_pulse, d1_ovf;
   logic           d1_valid, d1_pend;
   logic [1:0]     d1_ch;

   // Behavioural model: delay line of sampled inputs, per-channel pending
   // counts, the presented event and the round-robin pointer.
   logic [NCH-1:0] mdl_hist [0:DEP];
   int             mdl_cnt  [NCH];
   bit             mdl_v;
   int             mdl_c;
   int             mdl_p;
   logic [NCH-1:0] mdl_ovf;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;
   bit armed  = 1'b0;

`ifdef PULSE_SYNC_MC_OVF_EN
   localparam logic [NCH-1:0] OVF0_EXP = 4'b0001;
`else
   localparam logic [NCH-1:0] OVF0_EXP = 4'b0000;
`endif

   always #5 clk = ~clk;

   pulse_sync_mc #(
      .NUM_CH       (NCH),
      .DEPTH        (DEP),
      .CNT_W        (CW),
      .RST_VAL      (1'b0),
      .TOGGLE_EARLY (0)
   ) u_dut (
      .dst_clk    (clk),
      .dst_rst    (rst),
      .src_toggle (src),
      .dst_toggle (d_toggle),
      .dst_pulse  (d_pulse),
      .m_valid    (d_valid),
      .m_ready    (ready),
      .m_ch       (d_ch),
      .pend_any   (d_pend),
      .ovf        (d_ovf),
      .ovf_clr    (clr)
   );

   pulse_sync_mc #(
      .NUM_CH       (NCH),
      .DEPTH        (DEP),
      .CNT_W        (4),
      .RST_VAL      (1'b1),
      .TOGGLE_EARLY (0)
   ) u_dut1 (
      .dst_clk    (clk),
      .dst_rst    (rst),
      .src_toggle (src1),
      .dst_toggle (d1_toggle),
      .dst_pulse  (d1_pulse),
      .m_valid    (d1_valid),
      .m_ready    (ready1),
      .m_ch       (d1_ch),
      .pend_any   (d1_pend),
      .ovf        (d1_ovf),
      .ovf_clr    (clr1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance the model across one rising edge using the bench's own inputs.
   task automatic model_edge();
      logic [NCH-1:0] pul;
      int             win;
      int             n;
      bit             drop;
      if (rst) begin
         for (int d = 0; d <= DEP; d++) mdl_hist[d] = '0;
         for (int i = 0; i < NCH; i++) mdl_cnt[i] = 0;
         mdl_v   = 1'b0;
         mdl_c   = 0;
         mdl_p   = 0;
         mdl_ovf = '0;
         return;
      end
      pul = mdl_hist[DEP-1] ^ mdl_hist[DEP];
      win = -1;
      if (!mdl_v || ready) begin
         for (int k = 0; k < NCH; k++) begin
            int j;
            j = (mdl_p + k) % NCH;
            if (win < 0 && mdl_cnt[j] > 0) win = j;
         end
         mdl_v = (win >= 0);
         if (win >= 0) begin
            mdl_c = win;
            mdl_p = (win + 1) % NCH;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         n = mdl_cnt[i] + (pul[i] ? 1 : 0) - ((i == win) ? 1 : 0);
         drop = (n > CMAX);
         if (drop) n = CMAX;
         mdl_cnt[i] = n;
`ifdef PULSE_SYNC_MC_OVF_EN
         mdl_ovf[i] = (mdl_ovf[i] && !clr[i]) || drop;
`endif
      end
      for (int d = DEP; d > 0; d--) mdl_hist[d] = mdl_hist[d-1];
      mdl_hist[0] = src;
   endtask

   task automatic check_all();
      bit any;
      any = mdl_v;
      for (int i = 0; i < NCH; i++) if (mdl_cnt[i] > 0) any = 1'b1;
      chk("dst_pulse", 32'(d_pulse), 32'(mdl_hist[DEP-1] ^ mdl_hist[DEP]));
      chk("dst_toggle", 32'(d_toggle), 32'(mdl_hist[DEP-1]));
      chk("m_valid", 32'(d_valid), 32'(mdl_v));
      chk("m_ch", 32'(d_ch), 32'(mdl_c));
      chk("pend_any", 32'(d_pend), 32'(any));
      chk("ovf", 32'(d_ovf), 32'(mdl_ovf));
      chk("rv1_pulse", 32'(d1_pulse), 32'h0);
      chk("rv1_toggle", 32'(d1_toggle), 32'hF);
      chk("rv1_valid", 32'({d1_valid, d1_pend}), 32'h0);
      chk("rv1_ch_ovf", 32'({d1_ch, d1_ovf}), 32'h0);
   endtask

   task automatic tick();
      if (d_valid && ready) n_acc++;
      @(posedge clk);
      model_edge();
      #1;
      if (armed) check_all();
   endtask

   initial begin
      rst    = 1'b1;
      src    = '0;
      clr    = '0;
      ready  = 1'b1;
      src1   = '1;
      clr1   = '0;
      ready1 = 1'b1;
      tick();
      armed = 1'b1;
      tick();
      chk("reset_valid", 32'({d_valid, d_pend}), 32'h0);
      chk("reset_ovf", 32'(d_ovf), 32'h0);
      rst = 1'b0;

      // Channels 0, 2 and 3 toggle together; pointer starts at 0.
      src = 4'b1101;
      tick();
      tick();
      chk("multi_pulse", 32'(d_pulse), 32'hD);
      tick();
      tick();
      chk("multi_first", 32'({d_valid, d_ch}), 32'({1'b1, 2'd0}));
      tick();
      chk("multi_second", 32'({d_valid, d_ch}), 32'({1'b1, 2'd2}));
      tick();
      chk("multi_third", 32'({d_valid, d_ch}), 32'({1'b1, 2'd3}));
      tick();
      chk("multi_drained", 32'({d_valid, d_pend}), 32'h0);

      // Single toggle on channel 1: pulse after 2 edges, m_valid after 4.
      src[1] = 1'b1;
      tick();
      tick();
      chk("single_pulse", 32'(d_pulse), 32'h2);
      tick();
      chk("single_not_yet", 32'(d_valid), 32'h0);
      tick();
      chk("single_valid", 32'({d_valid, d_ch}), 32'({1'b1, 2'd1}));
      tick();
      chk("single_once", 32'(d_valid), 32'h0);

      // Five events on channel 0 with the consumer stalled.
      ready = 1'b0;
      for (int e = 0; e < 5; e++) begin
         src[0] = ~src[0];
         repeat (4) tick();
      end
      repeat (6) tick();
      chk("sat_ovf", 32'(d_ovf), 32'(OVF0_EXP));
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("hold_ch", 32'({d_valid, d_ch}), 32'({1'b1, 2'd0}));
      end
      clr = 4'b0001;
      tick();
      clr = '0;
      chk("ovf_cleared", 32'(d_ovf), 32'h0);
      ready = 1'b1;
      n_acc = 0;
      repeat (12) tick();
      chk("sat_delivered", 32'(n_acc), 32'd4);

      // Reset with three events outstanding discards them all.
      ready = 1'b0;
      src   = src ^ 4'b1110;
      repeat (6) tick();
      chk("pre_rst_pend", 32'({d_valid, d_pend}), 32'h3);
      rst = 1'b1;
      tick();
      chk("rst_discard", 32'({d_valid, d_pend}), 32'h0);
      rst   = 1'b0;
      ready = 1'b1;
      n_acc = 0;
      repeat (10) tick();
      chk("post_rst_none", 32'(n_acc), 32'd0);

      // Randomized traffic, stalls, clears and occasional resets.
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 2) == 0) src = src ^ 4'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         rst   = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst   = 1'b0;
      ready = 1'b1;
      clr   = '0;
      repeat (20) tick();
      chk("final_drained", 32'(d_pend), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
